// File: rtl/brisc_pkg.sv
// rtl/brisc_pkg.sv - shared widths and result lane indices
package brisc_pkg;

    localparam int XLEN      = 32;
    localparam int RES_LANES = 4;
    localparam int RES_SEL_W = 2;

    localparam int LANE_WB  = 0;
    localparam int LANE_CSR = 1;
    localparam int LANE_BR  = 2;
    localparam int LANE_DBG = 3;

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - per-lane result FIFO (WIDTH x DEPTH)
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (clears storage too)
//   push        write push_data at the tail; ignored when full
//   push_data   payload to write
//   full        count == DEPTH
//   pop         drop the head entry; ignored when empty
//   head_data   entry at the read pointer
//   empty       count == 0
module lane_fifo
    import brisc_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic do_push;
    logic do_pop;

    // full/empty come from registered count only, so a full lane that pops
    // this cycle still refuses the push; it is taken next cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_demux_1_4.sv
// rtl/result_demux_1_4.sv - 1:4 result stream demux with per-lane FIFOs
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   in_valid    upstream holds a result
//   in_ready    accepted this cycle; low while in reset or selected lane full
//   in_sel      destination lane 0..3
//   in_data     result payload
//   out_valid   per-lane head valid
//   out_ready   per-lane consumer take
//   out_data    lane i payload at out_data[i*WIDTH +: WIDTH]
//   busy        any lane holds data
module result_demux_1_4
    import brisc_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RES_SEL_W-1:0]       in_sel,
    input  logic [WIDTH-1:0]           in_data,
    output logic [RES_LANES-1:0]       out_valid,
    input  logic [RES_LANES-1:0]       out_ready,
    output logic [RES_LANES*WIDTH-1:0] out_data,
    output logic                       busy
);

    logic [RES_LANES-1:0] lane_full;
    logic [RES_LANES-1:0] lane_empty;
    logic [RES_LANES-1:0] lane_push;
    logic [RES_LANES-1:0] lane_pop;

    // Only registered lane state and in_sel feed in_ready; out_ready never does.
    assign in_ready = rst_n & ~lane_full[in_sel];
    assign busy     = |out_valid;

    for (genvar g = 0; g < RES_LANES; g++) begin : g_lane
        assign lane_push[g] = in_valid & in_ready & (in_sel == RES_SEL_W'(g));
        assign lane_pop[g]  = out_valid[g] & out_ready[g];
        assign out_valid[g] = ~lane_empty[g];

        lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (lane_push[g]),
            .push_data (in_data),
            .full      (lane_full[g]),
            .pop       (lane_pop[g]),
            .head_data (out_data[g*WIDTH +: WIDTH]),
            .empty     (lane_empty[g])
        );
    end

endmodule

// File: tb/tb_result_demux_1_4.sv
// tb/tb_result_demux_1_4.sv - self-checking bench for result_demux_1_4
module tb_result_demux_1_4;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [W-1:0] in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [4*W-1:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // reference: one queue per lane holding buffered values, plus a log of
    // values the consumers actually took
    logic [W-1:0] mq  [4][$];
    logic [W-1:0] got [4][$];
    logic         acc;

    result_demux_1_4 #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic cycle();
        logic [3:0] ev;
        int sel;
        #1;
        sel = int'(in_sel);
        acc = rst_n && in_valid && (mq[sel].size() != DEPTH);
        chk("in_ready", in_ready, rst_n && (mq[sel].size() != DEPTH));
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (out_ready[i] && mq[i].size() != 0) got[i].push_back(mq[i].pop_front());
            end
            if (acc) mq[sel].push_back(in_data);
        end
        #1;
        ev = '0;
        for (int i = 0; i < 4; i++) begin
            ev[i] = (mq[i].size() != 0);
            if (mq[i].size() > DEPTH) chk("model_depth", mq[i].size(), DEPTH);
        end
        chk("out_valid", out_valid, ev);
        chk("busy", busy, |ev);
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) chk($sformatf("out_data%0d", i), out_data[i*W +: W], mq[i][0]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 4'h0;

        // 1. reset with in_valid high
        cycle();
        cycle();
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cycle();
        chk("rst_nothing_enq", out_valid, 4'b0000);

        // 2. route one word to each lane, consumers always ready
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i);
            in_data  = 32'hA000_0000 + 32'(i);
            cycle();
            chk("route_acc", acc, 1'b1);
            chk("route_visible", out_valid[i], 1'b1);
            chk("route_data", out_data[i*W +: W], 32'hA000_0000 + 32'(i));
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("route_drain_n", got[i].size(), 1);
            if (got[i].size() == 1) chk("route_drain_v", got[i][0], 32'hA000_0000 + 32'(i));
            got[i].delete();
        end

        // 3. fill lane 2, third push refused, lane 0 still accepts
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'hB1; cycle(); chk("full_acc1", acc, 1'b1);
        in_data   = 32'hB2; cycle(); chk("full_acc2", acc, 1'b1);
        in_data   = 32'hB3; cycle(); chk("full_rej3", acc, 1'b0);
        in_sel    = 2'd0;
        in_data   = 32'hC0; cycle(); chk("full_other_lane", acc, 1'b1);

        // 4. full lane pops while third push is held: refused now, taken next
        in_sel    = 2'd2;
        in_data   = 32'hB3;
        out_ready = 4'hF;
        cycle(); chk("popcycle_rej", acc, 1'b0);
        cycle(); chk("popcycle_acc", acc, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("order_n", got[2].size(), 3);
        if (got[2].size() == 3) begin
            chk("order_1", got[2][0], 32'hB1);
            chk("order_2", got[2][1], 32'hB2);
            chk("order_3", got[2][2], 32'hB3);
        end
        for (int i = 0; i < 4; i++) got[i].delete();

        // 5. stream 1..10 through lane 1 across pointer wrap
        in_valid = 1'b1;
        in_sel   = 2'd1;
        for (int v = 1; v <= 10; v++) begin
            in_data = 32'(v);
            cycle();
            chk("wrap_acc", acc, 1'b1);
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("wrap_n", got[1].size(), 10);
        for (int v = 0; v < 10 && v < got[1].size(); v++) chk("wrap_seq", got[1][v], 32'(v + 1));
        for (int i = 0; i < 4; i++) got[i].delete();

        // 6. mid-operation reset discards buffered data
        out_ready = 4'h0;
        in_valid  = 1'b1;
        in_sel    = 2'd0; in_data = 32'hD0; cycle();
        in_sel    = 2'd3; in_data = 32'hD3; cycle();
        chk("midrst_pre", out_valid, 4'b1001);
        rst_n = 1'b0;
        cycle();
        chk("midrst_valid", out_valid, 4'b0000);
        chk("midrst_busy", busy, 1'b0);
        rst_n     = 1'b1;
        in_data   = 32'hE3;
        cycle();
        in_valid  = 1'b0;
        out_ready = 4'hF;
        cycle();
        cycle();
        chk("midrst_only_n", got[3].size() + got[0].size(), 1);
        if (got[3].size() == 1) chk("midrst_only_v", got[3][0], 32'hE3);
        for (int i = 0; i < 4; i++) got[i].delete();

        // randomized traffic, honouring the hold-while-stalled upstream rule
        for (int n = 0; n < 400; n++) begin
            if (!(in_valid && !acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = $urandom;
            end
            out_ready = 4'($urandom);
            rst_n     = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
